// File: rtl/flappy_pipe_ctrl.sv
// Pipe scroller, collision detector and score keeper for the Flappy game.
// Optional macro FLAPPY_SCORE_SAT_EN makes Score saturate at 255 instead of wrapping.
module flappy_pipe_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int PIPE_W       = 40,
    parameter int GAP_H        = 120,
    parameter int PIPE_SPACING = 320,
    parameter int BIRD_SIZE    = 16,
    parameter int SPEED        = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Run,
    input  logic       Clear,
    input  logic [9:0] XBird,
    input  logic [9:0] YBird,
    output logic [9:0] Pipe0X,
    output logic [9:0] Pipe1X,
    output logic [9:0] Pipe0GapY,
    output logic [9:0] Pipe1GapY,
    output logic       Collision,
    output logic [7:0] Score,
    output logic       ScorePulse
);

    typedef enum logic [1:0] {IDLE, SCROLL, CHECK, HIT} state_e;

    localparam logic [9:0]  X0_RST    = 10'(SCREEN_W);
    localparam logic [9:0]  X1_RST    = 10'(SCREEN_W + PIPE_SPACING);
    localparam logic [9:0]  GAP_RST   = 10'd200;
    localparam logic [9:0]  GAP_BASE  = 10'd40;
    localparam logic [9:0]  SPEED_V   = 10'(SPEED);
    localparam logic [7:0]  LFSR_RST  = 8'hA5;
    localparam logic [10:0] PIPE_W11  = 11'(PIPE_W);
    localparam logic [10:0] BIRD11    = 11'(BIRD_SIZE);
    localparam logic [10:0] GAP11     = 11'(GAP_H);
    localparam logic [10:0] SCREEN_H11 = 11'(SCREEN_H);

    state_e          state_q, state_d;
    logic [1:0][9:0] pipeX_q, pipeX_d;
    logic [1:0][9:0] gapY_q, gapY_d;
    logic [1:0]      scored_q, scored_d;
    logic [7:0]      lfsr_q, lfsr_d, lfsrNext;
    logic [7:0]      score_q, score_d;
    logic            pulse_q, pulse_d;
    logic            coll_q, coll_d;

    logic [1:0]      pipeHit, pipePassed;
    logic            floorHit;
    logic [1:0]      passCount;
    logic [8:0]      scoreSum;

    // Maximal-length taps, so the all-zero lockup state is never entered from A5.
    assign lfsrNext = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        pipeHit    = '0;
        pipePassed = '0;
        floorHit   = ({1'b0, YBird} + BIRD11) >= SCREEN_H11;
        for (int i = 0; i < 2; i++) begin
            pipeHit[i] = ({1'b0, XBird} < {1'b0, pipeX_q[i]} + PIPE_W11)
                      && ({1'b0, XBird} + BIRD11 > {1'b0, pipeX_q[i]})
                      && (({1'b0, YBird} < {1'b0, gapY_q[i]})
                       || ({1'b0, YBird} + BIRD11 > {1'b0, gapY_q[i]} + GAP11));
            pipePassed[i] = ({1'b0, pipeX_q[i]} + PIPE_W11 < {1'b0, XBird}) && !scored_q[i];
        end
        passCount = {1'b0, pipePassed[0]} + {1'b0, pipePassed[1]};
        scoreSum  = {1'b0, score_q} + {7'b0, passCount};
    end

    always_comb begin
        state_d  = state_q;
        pipeX_d  = pipeX_q;
        gapY_d   = gapY_q;
        scored_d = scored_q;
        lfsr_d   = lfsr_q;
        score_d  = score_q;
        pulse_d  = 1'b0;
        coll_d   = coll_q;

        case (state_q)
            IDLE: begin
                if (Run) state_d = SCROLL;
            end
            SCROLL: begin
                if (Tick && Run) begin
                    state_d = CHECK;
                    lfsr_d  = lfsrNext;
                    for (int i = 0; i < 2; i++) begin
                        if (pipeX_q[i] < SPEED_V) begin
                            pipeX_d[i]  = X0_RST;
                            gapY_d[i]   = GAP_BASE + {2'b00, lfsrNext};
                            scored_d[i] = 1'b0;
                        end else begin
                            pipeX_d[i] = pipeX_q[i] - SPEED_V;
                        end
                    end
                end
            end
            CHECK: begin
                coll_d   = floorHit || (|pipeHit);
                state_d  = (floorHit || (|pipeHit)) ? HIT : SCROLL;
                scored_d = scored_q | pipePassed;
                pulse_d  = |pipePassed;
`ifdef FLAPPY_SCORE_SAT_EN
                score_d  = scoreSum[8] ? 8'hFF : scoreSum[7:0];
`else
                score_d  = scoreSum[7:0];
`endif
            end
            HIT: begin
                state_d = HIT;
            end
            default: state_d = IDLE;
        endcase

        // New game wins over everything, but the LFSR keeps running across games.
        if (Clear) begin
            state_d  = IDLE;
            pipeX_d  = {X1_RST, X0_RST};
            gapY_d   = {GAP_RST, GAP_RST};
            scored_d = '0;
            lfsr_d   = lfsr_q;
            score_d  = '0;
            pulse_d  = 1'b0;
            coll_d   = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            pipeX_q  <= {X1_RST, X0_RST};
            gapY_q   <= {GAP_RST, GAP_RST};
            scored_q <= '0;
            lfsr_q   <= LFSR_RST;
            score_q  <= '0;
            pulse_q  <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pipeX_q  <= pipeX_d;
            gapY_q   <= gapY_d;
            scored_q <= scored_d;
            lfsr_q   <= lfsr_d;
            score_q  <= score_d;
            pulse_q  <= pulse_d;
            coll_q   <= coll_d;
        end
    end

    assign Pipe0X     = pipeX_q[0];
    assign Pipe1X     = pipeX_q[1];
    assign Pipe0GapY  = gapY_q[0];
    assign Pipe1GapY  = gapY_q[1];
    assign Collision  = coll_q;
    assign Score      = score_q;
    assign ScorePulse = pulse_q;

endmodule

// File: tb/tb_flappy_pipe_ctrl.sv
// Self-checking bench for flappy_pipe_ctrl: directed game scenarios plus randomized play
// compared every cycle against a behavioural game model.
module tb_flappy_pipe_ctrl;

    localparam int W       = 640;
    localparam int H       = 480;
    localparam int PW      = 40;
    localparam int GAP     = 120;
    localparam int SPACING = 320;
    localparam int BIRD    = 16;

    logic       Clk = 1'b0;
    logic       Reset, Tick, Run, Clear;
    logic [9:0] XBird, YBird;

    logic [9:0] p0xS, p1xS, g0S, g1S, p0xF, p1xF, g0F, g1F;
    logic [7:0] scS, scF;
    logic       coS, plS, coF, plF;

    flappy_pipe_ctrl dutSlow (
        .Clk(Clk), .Reset(Reset), .Tick(Tick), .Run(Run), .Clear(Clear),
        .XBird(XBird), .YBird(YBird),
        .Pipe0X(p0xS), .Pipe1X(p1xS), .Pipe0GapY(g0S), .Pipe1GapY(g1S),
        .Collision(coS), .Score(scS), .ScorePulse(plS)
    );

    flappy_pipe_ctrl #(.SPEED(40)) dutFast (
        .Clk(Clk), .Reset(Reset), .Tick(Tick), .Run(Run), .Clear(Clear),
        .XBird(XBird), .YBird(YBird),
        .Pipe0X(p0xF), .Pipe1X(p1xF), .Pipe0GapY(g0F), .Pipe1GapY(g1F),
        .Collision(coF), .Score(scF), .ScorePulse(plF)
    );

    always #5 Clk = ~Clk;

    int compared   = 0;
    int mismatched = 0;
    bit useFast    = 1'b0;
    int pulseSeen, colSeen;

    // Game model: 0 waiting for Run, 1 scrolling, 2 judging a frame, 3 crashed
    int mMode, mSpeed, mScore, mPasses, mLfsr;
    int mPx[2], mGy[2];
    bit mScored[2];
    bit mPulse, mCol;

    task automatic modelClear();
        mMode = 0;
        mPx[0] = W; mPx[1] = W + SPACING;
        mGy[0] = 200; mGy[1] = 200;
        mScored[0] = 0; mScored[1] = 0;
        mScore = 0; mPasses = 0; mPulse = 0; mCol = 0;
    endtask

    task automatic modelReset();
        modelClear();
        mLfsr = 8'hA5;
    endtask

    task automatic modelStep();
        int passN;
        bit crash;
        if (Reset) begin modelReset(); return; end
        mPulse = 0;
        if (Clear) begin modelClear(); return; end
        case (mMode)
            0: if (Run) mMode = 1;
            1: if (Tick && Run) begin
                mLfsr = ((mLfsr << 1) & 255) | (((mLfsr >> 7) ^ (mLfsr >> 5) ^ (mLfsr >> 4) ^ (mLfsr >> 3)) & 1);
                for (int i = 0; i < 2; i++) begin
                    if (mPx[i] < mSpeed) begin
                        mPx[i] = W; mGy[i] = 40 + mLfsr; mScored[i] = 0;
                    end else begin
                        mPx[i] = mPx[i] - mSpeed;
                    end
                end
                mMode = 2;
            end
            2: begin
                crash = (int'(YBird) + BIRD >= H);
                passN = 0;
                for (int i = 0; i < 2; i++) begin
                    if (int'(XBird) < mPx[i] + PW && int'(XBird) + BIRD > mPx[i] &&
                        (int'(YBird) < mGy[i] || int'(YBird) + BIRD > mGy[i] + GAP))
                        crash = 1;
                    if (mPx[i] + PW < int'(XBird) && !mScored[i]) begin
                        passN++; mScored[i] = 1;
                    end
                end
                mPasses += passN;
                if (passN > 0) mPulse = 1;
`ifdef FLAPPY_SCORE_SAT_EN
                mScore = (mScore + passN > 255) ? 255 : mScore + passN;
`else
                mScore = (mScore + passN) % 256;
`endif
                mCol  = crash;
                mMode = crash ? 3 : 1;
            end
            default: ;
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkAll();
        if (useFast) begin
            checkOutput("fast.Pipe0X", p0xF, mPx[0]);
            checkOutput("fast.Pipe1X", p1xF, mPx[1]);
            checkOutput("fast.Pipe0GapY", g0F, mGy[0]);
            checkOutput("fast.Pipe1GapY", g1F, mGy[1]);
            checkOutput("fast.Score", scF, mScore);
            checkOutput("fast.ScorePulse", plF, mPulse);
            checkOutput("fast.Collision", coF, mCol);
        end else begin
            checkOutput("Pipe0X", p0xS, mPx[0]);
            checkOutput("Pipe1X", p1xS, mPx[1]);
            checkOutput("Pipe0GapY", g0S, mGy[0]);
            checkOutput("Pipe1GapY", g1S, mGy[1]);
            checkOutput("Score", scS, mScore);
            checkOutput("ScorePulse", plS, mPulse);
            checkOutput("Collision", coS, mCol);
        end
    endtask

    task automatic clockCycle();
        @(posedge Clk);
        modelStep();
        #1;
        if (plS) pulseSeen++;
        if (coS) colSeen++;
        checkAll();
    endtask

    task automatic applyStimulus(input bit tick, input bit run, input bit clear);
        Tick = tick; Run = run; Clear = clear;
        clockCycle();
        Tick = 1'b0; Clear = 1'b0;
    endtask

    task automatic doTicks(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        bit prevTick;
        bit tk;
        int guard;
        int expFinal;

        Reset = 1'b1; Tick = 1'b0; Run = 1'b0; Clear = 1'b0;
        XBird = 10'd100; YBird = 10'd200;
        mSpeed = 2;
        modelReset();
        #12;
        checkOutput("rst.Pipe0X", p0xS, 640);
        checkOutput("rst.Pipe1X", p1xS, 960);
        checkOutput("rst.GapY0", g0S, 200);
        checkOutput("rst.GapY1", g1S, 200);
        checkOutput("rst.Score", scS, 0);
        checkOutput("rst.Collision", coS, 0);
        Reset = 1'b0;

        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("noRun.Pipe0X", p0xS, 640);

        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("tick1.Pipe0X", p0xS, 638);
        checkOutput("tick1.Pipe1X", p1xS, 958);
        checkOutput("tick1.Collision", coS, 0);

        pulseSeen = 0; colSeen = 0;
        doTicks(290);
        checkOutput("pass.Pipe0X", p0xS, 58);
        checkOutput("pass.Score", scS, 1);
        checkOutput("pass.pulseCycles", pulseSeen, 1);
        checkOutput("pass.collisionCycles", colSeen, 0);

        applyStimulus(1'b0, 1'b1, 1'b1);
        YBird = 10'd100;
        applyStimulus(1'b0, 1'b1, 1'b0);
        doTicks(263);
        checkOutput("crash.Pipe0X", p0xS, 114);
        checkOutput("crash.Collision", coS, 1);
        doTicks(5);
        checkOutput("hit.Pipe0X", p0xS, 114);
        checkOutput("hit.Collision", coS, 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("clear.Pipe0X", p0xS, 640);
        checkOutput("clear.Collision", coS, 0);
        checkOutput("clear.Score", scS, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("idle.tickIgnored", p0xS, 640);

        YBird = 10'd470;
        doTicks(1);
        checkOutput("floor.Collision", coS, 1);
        checkOutput("floor.Pipe0X", p0xS, 638);

        applyStimulus(1'b0, 1'b1, 1'b1);
        YBird = 10'd200;
        applyStimulus(1'b0, 1'b1, 1'b0);
        doTicks(10);
        Tick = 1'b1;
        clockCycle();
        Tick = 1'b0;
        Reset = 1'b1;
        #1;
        modelReset();
        checkOutput("asyncRst.Pipe0X", p0xS, 640);
        checkOutput("asyncRst.Pipe1X", p1xS, 960);
        checkAll();
        @(negedge Clk);
        Reset = 1'b0;

        prevTick = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            tk = !prevTick && ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) begin
                XBird = 10'($urandom_range(0, 1000));
                YBird = 10'($urandom_range(0, 470));
            end
            applyStimulus(tk, $urandom_range(0, 9) != 0, $urandom_range(0, 99) < 2);
            prevTick = tk;
        end

        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        useFast = 1'b1;
        mSpeed = 40;
        modelReset();
        XBird = 10'd1000; YBird = 10'd0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        guard = 0;
        while (mPasses < 256 && guard < 4000) begin
            doTicks(1);
            guard++;
        end
`ifdef FLAPPY_SCORE_SAT_EN
        expFinal = (mPasses > 255) ? 255 : mPasses;
`else
        expFinal = mPasses % 256;
`endif
        checkOutput("wrap.Score", scF, expFinal);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
